// File: rtl/mem_req_router_pkg.sv
// Shared constants and target encoding for the MEM-stage request router.
package mem_req_router_pkg;
  localparam int kDataWidth = 32;
  localparam logic [kDataWidth-1:0] kMmioBase = 32'h1000_0000;
  localparam int kRouterDepth = 4;

  typedef enum logic {
    TGT_DMEM = 1'b0,
    TGT_MMIO = 1'b1
  } target_e;
endpackage

// File: rtl/mem_req_router_tag_fifo.sv
// 1-bit tag FIFO remembering which target each outstanding load went to.
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] kPtrOne = AW'(1);
  localparam logic [AW:0] kCntOne = (AW + 1)'(1);
  localparam logic [AW:0] kCntFull = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] count;
  logic push_ok;
  logic pop_ok;

  assign full = (count == kCntFull);
  assign empty = (count == '0);
  assign head = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + kPtrOne;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + kPtrOne;
      end
      if (push_ok && !pop_ok) begin
        count <= count + kCntOne;
      end else if (pop_ok && !push_ok) begin
        count <= count - kCntOne;
      end
    end
  end
endmodule

// File: rtl/mem_req_router.sv
// Routes MEM-stage loads/stores to data memory (target 0) or MMIO (target 1) and
// returns load data in request order. Define MEM_REQ_ROUTER_STATS_EN for stall_cycles.
module mem_req_router
  import mem_req_router_pkg::*;
#(
  parameter int DATA_WIDTH = kDataWidth,
  parameter logic [DATA_WIDTH-1:0] MMIO_BASE = kMmioBase,
  parameter int DEPTH = kRouterDepth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_we,
  output logic                  out0_valid,
  output logic                  out1_valid,
  input  logic                  out0_ready,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic                  out_we,
  input  logic                  rsp0_valid,
  input  logic                  rsp1_valid,
  input  logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp0_ready,
  output logic                  rsp1_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_ready
`ifdef MEM_REQ_ROUTER_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);
  target_e req_sel;
  target_e hold_sel;
  logic hold_v;
  logic hold_free;
  logic accept;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic push;
  logic pop;

  assign req_sel = (req_addr >= MMIO_BASE) ? TGT_MMIO : TGT_DMEM;
  assign hold_free = ~hold_v | ((hold_sel == TGT_MMIO) ? out1_ready : out0_ready);
  // A full tag FIFO blocks stores as well, keeping req_ready independent of req_we
  assign req_ready = hold_free & ~fifo_full;
  assign accept = req_valid & req_ready;
  assign out0_valid = hold_v & (hold_sel == TGT_DMEM);
  assign out1_valid = hold_v & (hold_sel == TGT_MMIO);

  // Hold register: refilled on acceptance, emptied once the selected target takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v <= 1'b0;
      hold_sel <= TGT_DMEM;
      out_addr <= '0;
      out_wdata <= '0;
      out_we <= 1'b0;
    end else if (accept) begin
      hold_v <= 1'b1;
      hold_sel <= req_sel;
      out_addr <= req_addr;
      out_wdata <= req_wdata;
      out_we <= req_we;
    end else if (hold_free) begin
      hold_v <= 1'b0;
    end
  end

  assign push = accept & ~req_we;
  assign pop = rsp_valid & rsp_ready;

  tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(req_sel),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // Only the target at the head of the tag FIFO is ever acknowledged
  assign rsp_valid = ~fifo_empty & (fifo_head ? rsp1_valid : rsp0_valid);
  assign rsp_rdata = fifo_head ? rsp1_rdata : rsp0_rdata;
  assign rsp0_ready = rsp_ready & ~fifo_empty & ~fifo_head;
  assign rsp1_ready = rsp_ready & ~fifo_empty & fifo_head;

`ifdef MEM_REQ_ROUTER_STATS_EN
  localparam logic [31:0] kStallMax = 32'hFFFF_FFFF;

  // Saturating count of cycles in which a valid request was held off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
    end else if (req_valid && !req_ready && (stall_cycles != kStallMax)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule
